// File: rtl/gray_cnt_pkg.sv
// gray_cnt_pkg -- shared definitions for the SR-based Gray counter.
//   WIDTH_MIN / WIDTH_MAX : legal range of the counter width
//   RST_VAL_DEF           : default Gray code loaded on reset
//   bin2gray / gray2bin   : code conversions on a WIDTH_MAX-wide word;
//                           callers zero-extend narrower values in and
//                           truncate results back out.
//   nxt_src_e             : which source feeds the next Gray code
package gray_cnt_pkg;

  localparam int          WIDTH_MIN   = 2;
  localparam int          WIDTH_MAX   = 16;
  localparam int unsigned RST_VAL_DEF = 0;

  typedef logic [WIDTH_MAX-1:0] cw_t;

  typedef enum logic [1:0] {
    SRC_HOLD,
    SRC_LOAD,
    SRC_UP,
    SRC_DOWN
  } nxt_src_e;

  function automatic cw_t bin2gray(input cw_t b);
    return b ^ (b >> 1);
  endfunction

  // XOR-prefix from the MSB down; zero-extended upper bits leave the
  // lower bits of the result unaffected.
  function automatic cw_t gray2bin(input cw_t g);
    cw_t b;
    b[WIDTH_MAX-1] = g[WIDTH_MAX-1];
    for (int i = WIDTH_MAX - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/sr_reg_bit.sv
// sr_reg_bit -- one synchronous SR storage bit.
//   clk     : clock, rising edge
//   c       : synchronous active-high clear, loads rst_val
//   rst_val : value taken on clear
//   S, R    : set / reset drive; next = S | (Q & ~R)
//   Q, Qb   : stored bit and its complement
module sr_reg_bit (
  input  logic clk,
  input  logic c,
  input  logic rst_val,
  input  logic S,
  input  logic R,
  output logic Q,
  output logic Qb
);

  always_ff @(posedge clk) begin
    if (c) Q <= rst_val;
    else   Q <= S | (Q & ~R);
  end

  assign Qb = ~Q;

  // The drive logic upstream derives S and R from one target value, so
  // both high at once means that logic is broken.
  a_no_sr_conflict: assert property (@(posedge clk) !(S && R));

endmodule

// File: rtl/gray_counter_sr.sv
// gray_counter_sr -- up/down Gray counter built from SR storage bits.
//   clk    : clock, rising edge
//   c      : synchronous active-high clear to RST_VAL (beats ld and en)
//   en     : count enable
//   up     : 1 = count up, 0 = count down
//   ld     : synchronous load of ld_val (beats en)
//   ld_val : Gray code to load
//   Q, Qb  : registered Gray count and its complement
//   tc     : terminal count for the current direction (from Q and up)
//   bin    : binary equivalent of Q, present only with GRAY_CNT_BIN_OUT_EN
// Parameters: WIDTH (2..16), RST_VAL (Gray code loaded on clear).
module gray_counter_sr
  import gray_cnt_pkg::*;
#(
  parameter int          WIDTH   = 4,
  parameter int unsigned RST_VAL = RST_VAL_DEF
) (
  input  logic             clk,
  input  logic             c,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb,
  output logic             tc
`ifdef GRAY_CNT_BIN_OUT_EN
  ,
  output logic [WIDTH-1:0] bin
`endif
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("gray_counter_sr: WIDTH out of range");
  end

  localparam logic [WIDTH-1:0] RST_G    = RST_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] TOP_CODE = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] bin_cur, bin_inc, bin_dec;
  logic [WIDTH-1:0] nxt, s_drv, r_drv;
  nxt_src_e         src;

  // Stepping goes through binary: +/-1 there and re-encoding gives the
  // neighbouring Gray code, wrap included, with a single bit flip.
  assign bin_cur = WIDTH'(gray2bin(cw_t'(Q)));
  assign bin_inc = bin_cur + WIDTH'(1);
  assign bin_dec = bin_cur - WIDTH'(1);

  // Clear is applied inside each storage bit, so only ld > en remains.
  always_comb begin
    src = SRC_HOLD;
    if (ld)      src = SRC_LOAD;
    else if (en) src = up ? SRC_UP : SRC_DOWN;
  end

  always_comb begin
    nxt = Q;
    case (src)
      SRC_LOAD: nxt = ld_val;
      SRC_UP:   nxt = WIDTH'(bin2gray(cw_t'(bin_inc)));
      SRC_DOWN: nxt = WIDTH'(bin2gray(cw_t'(bin_dec)));
      default:  nxt = Q;
    endcase
  end

  // Set only bits rising, reset only bits falling: S and R are disjoint.
  assign s_drv = nxt & ~Q;
  assign r_drv = ~nxt & Q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_reg_bit u_bit (
      .clk     (clk),
      .c       (c),
      .rst_val (RST_G[i]),
      .S       (s_drv[i]),
      .R       (r_drv[i]),
      .Q       (Q[i]),
      .Qb      (Qb[i])
    );
  end

  assign tc = up ? (Q == TOP_CODE) : (Q == '0);

`ifdef GRAY_CNT_BIN_OUT_EN
  // Taps the decode the stepping logic already needs.
  assign bin = bin_cur;
`endif

endmodule

// File: tb/tb_gray_counter_sr.sv
module tb_gray_counter_sr;

  localparam int W = 4;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         c = 1'b0, en = 1'b0, up = 1'b1, ld = 1'b0;
  logic [W-1:0] ld_val = '0;
  logic [W-1:0] q, qb;
  logic         tc;
`ifdef GRAY_CNT_BIN_OUT_EN
  logic [W-1:0] bin;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gray_counter_sr #(.WIDTH(W), .RST_VAL(0)) dut (
    .clk    (clk),
    .c      (c),
    .en     (en),
    .up     (up),
    .ld     (ld),
    .ld_val (ld_val),
    .Q      (q),
    .Qb     (qb),
    .tc     (tc)
`ifdef GRAY_CNT_BIN_OUT_EN
    ,
    .bin    (bin)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Position of a Gray code in the counting sequence, found by search.
  function automatic int code_index(input int g);
    for (int i = 0; i < N; i++) if ((i ^ (i >> 1)) == g) return i;
    return 0;
  endfunction

  // Model: the count is a plain integer position 0..N-1.
  int           m       = 0;
  bit           mv      = 1'b0;
  bit           counted = 1'b0;
  logic [W-1:0] last_q;

  always @(posedge clk) begin
    counted = 1'b0;
    if (c) begin
      m  = 0;
      mv = 1'b1;
    end else if (ld) begin
      m = code_index(int'(ld_val));
    end else if (en) begin
      m = up ? (m + 1) % N : (m + N - 1) % N;
      counted = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      chk("model_q",  q,  32'(m ^ (m >> 1)));
      chk("model_qb", qb, 32'((~(m ^ (m >> 1))) & (N - 1)));
      chk("model_tc", tc, 32'(up ? (m == N - 1) : (m == 0)));
`ifdef GRAY_CNT_BIN_OUT_EN
      chk("model_bin", bin, 32'(m));
`endif
      if (counted) chk("one_bit_step", $countones(q ^ last_q), 1);
      last_q = q;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] up_tbl [N] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                               4'b0110, 4'b0111, 4'b0101, 4'b0100,
                               4'b1100, 4'b1101, 4'b1111, 4'b1110,
                               4'b1010, 4'b1011, 4'b1001, 4'b1000};

  initial begin
    // reset
    c = 1'b1;
    step();
    c = 1'b0; up = 1'b1; #1;
    chk("rst_q",  q,  4'b0000);
    chk("rst_qb", qb, 4'b1111);
    chk("rst_tc", tc, 1'b0);

    // full up sequence with wrap
    en = 1'b1;
    for (int i = 0; i < N; i++) begin
      chk("up_seq", q, up_tbl[i]);
      if (i == N - 1) chk("up_tc", tc, 1'b1);
      step();
    end
    chk("up_wrap", q, 4'b0000);

    // down wrap
    up = 1'b0; #1;
    chk("dn_tc", tc, 1'b1);
    step();
    chk("dn_wrap", q, 4'b1000);
    step();
    chk("dn_next", q, 4'b1001);

    // priority: ld over en, c over ld
    en = 1'b0; ld = 1'b1; ld_val = 4'b0110;
    step();
    chk("pri_pre", q, 4'b0110);
    ld_val = 4'b1011; en = 1'b1;
    step();
    chk("pri_ld", q, 4'b1011);
    c = 1'b1;
    step();
    chk("pri_c", q, 4'b0000);
    c = 1'b0; ld = 1'b0; up = 1'b1;
    step();
    chk("resume", q, 4'b0001);

    // hold with up toggling
    en = 1'b0; ld = 1'b1; ld_val = 4'b0101;
    step();
    ld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up = ~up;
      step();
      chk("hold_q",  q,  4'b0101);
      chk("hold_qb", qb, 4'b1010);
    end

    // direction change while enabled
    en = 1'b1; up = 1'b1;
    step();
    chk("dir_up", q, 4'b0100);
    up = 1'b0;
    step();
    chk("dir_dn1", q, 4'b0101);
    step();
    chk("dir_dn2", q, 4'b0111);

`ifdef GRAY_CNT_BIN_OUT_EN
    en = 1'b0; ld = 1'b1; ld_val = 4'b1110;
    step();
    chk("bin_1110", bin, 4'b1011);
    ld_val = 4'b1000;
    step();
    chk("bin_1000", bin, 4'b1111);
`endif

    // mixed walk checked by the model every cycle
    ld = 1'b0;
    for (int i = 0; i < 48; i++) begin
      en = (i % 5) != 0;
      up = (i % 7) < 4;
      ld = (i % 13) == 12;
      ld_val = 4'(i * 3);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_counter_sr.md
GRAY_COUNTER_SR -- requirements
Module: gray_counter_sr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning counter width in bits; legal range 2..16.
REQ-002 The block SHALL have parameter RST_VAL, default 0, meaning the Gray-coded value loaded on reset.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port c  input  1  synchronous, active-high reset (clear), sampled on rising clk.
REQ-005 The block SHALL have port en  input  1  count enable.
REQ-006 The block SHALL have port up  input  1  direction: 1 counts up, 0 counts down.
REQ-007 The block SHALL have port ld  input  1  synchronous load strobe.
REQ-008 The block SHALL have port ld_val  input  WIDTH  Gray-coded value to load.
REQ-009 The block SHALL have port Q  output  WIDTH  current count, Gray-coded, registered.
REQ-010 The block SHALL have port Qb  output  WIDTH  bitwise complement of Q, always.
REQ-011 The block SHALL have port tc  output  1  terminal count for current direction, combinational from Q and up.

Function
REQ-012 The state SHALL be WIDTH SR storage bits, each updated from its S/R pair, with next-state given by Q+ = S | (Q & ~R).
REQ-013 Per-bit drive SHALL be S = next & ~Q and R = ~next & Q, so S=R=1 never occurs; an internal assertion SHALL flag it.
REQ-014 Priority SHALL be c > ld > en; with none asserted, Q holds.
REQ-015 ld=1, c=0: Q SHALL equal ld_val on the next edge, regardless of en and up.
REQ-016 en=1, ld=0, c=0, up=1: Q SHALL advance one Gray step: gray(bin(Q)+1 mod 2^WIDTH).
REQ-017 en=1, ld=0, c=0, up=0: Q SHALL retreat one Gray step: gray(bin(Q)-1 mod 2^WIDTH).
REQ-018 Exactly one bit of Q SHALL change per count step, including at wrap-around.
REQ-019 Up wrap: Q = 1 followed by WIDTH-1 zeros SHALL be followed by all zeros; down wrap SHALL be the reverse.
REQ-020 tc SHALL be 1 when up=1 and Q = 1 followed by zeros, or when up=0 and Q = 0; tc SHALL be independent of en.
REQ-021 Latency SHALL be one clock from en, ld or c to the updated Q.
REQ-022 Changing up while en=1 SHALL take effect on the same edge, with no skipped or repeated code.

Reset
REQ-023 With c=1 on a rising edge, Q SHALL become RST_VAL, Qb ~RST_VAL, and tc SHALL follow from RST_VAL and up.
REQ-024 Reset mid-count SHALL override simultaneous ld and en on that edge; counting SHALL resume from RST_VAL on the next enabled edge.
REQ-025 Before the first reset edge, Q SHALL be treated as undefined; no asynchronous path SHALL exist.

Configuration
REQ-026 Macro GRAY_CNT_BIN_OUT_EN SHALL control an extra output port bin  output  WIDTH  binary equivalent of Q, combinational XOR-prefix decode.
REQ-027 Without GRAY_CNT_BIN_OUT_EN, port bin and its decode logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Shared package gray_cnt_pkg SHALL hold the gray-to-binary and binary-to-gray functions, the WIDTH legal-range constants, and the default RST_VAL.
REQ-029 One sub-module sr_reg_bit SHALL implement a single synchronous SR storage bit with ports clk, c, rst_val, S, R, Q, Qb, instantiated WIDTH times.
REQ-030 The next-state, SR-drive and tc logic SHALL live in gray_counter_sr.

Verification (WIDTH=4, RST_VAL=0)
REQ-031 Reset test: c=1 for one edge, then c=0 -> Q=0000, Qb=1111, tc=0 with up=1.
REQ-032 Up-count test: en=1, up=1 for 16 edges -> Q = 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000; tc=1 at 1000; next Q=0000.
REQ-033 Down-wrap test: from Q=0000, en=1, up=0 -> tc=1 before the edge; Q=1000 after it; next Q=1001.
REQ-034 Priority test: at Q=0110, ld=1, ld_val=1011, en=1 -> Q=1011; then c=1, ld=1 together -> Q=0000.
REQ-035 Hold test: en=0 for 5 edges at Q=0101 with up toggling -> Q stays 0101, Qb=1010.
REQ-036 Binary-output test, GRAY_CNT_BIN_OUT_EN defined: Q=1110 -> bin=1011; Q=1000 -> bin=1111; monitor SHALL confirm S&R never both 1 and one bit changes per step.
